// File: rtl/l2_mem_arbiter.sv
// Round-robin arbiter sharing one TileLink-UL memory port among NUM_BANK L2 banks.
// A requests go through a one-entry registered stage; D responses route back by the bank tag in the source.
module l2_mem_arbiter #(
    parameter int NUM_BANK        = 2,
    parameter int BANK_BITS       = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1,
    parameter int OP_BITS         = 3,
    parameter int SIZE_BITS       = 3,
    parameter int SOURCE_BITS     = 8,
    parameter int ADDRESS_BITS    = 32,
    parameter int DATA_BITS       = 64,
    parameter int MASK_BITS       = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_BITS        = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic [NUM_BANK-1:0]                in_a_valid,
    output logic [NUM_BANK-1:0]                in_a_ready,
    input  logic [NUM_BANK*OP_BITS-1:0]        in_a_opcode,
    input  logic [NUM_BANK*SIZE_BITS-1:0]      in_a_size,
    input  logic [NUM_BANK*SOURCE_BITS-1:0]    in_a_source,
    input  logic [NUM_BANK*ADDRESS_BITS-1:0]   in_a_address,
    input  logic [NUM_BANK*MASK_BITS-1:0]      in_a_mask,
    input  logic [NUM_BANK*DATA_BITS-1:0]      in_a_data,
    input  logic [NUM_BANK*3-1:0]              in_a_param,
    output logic [NUM_BANK-1:0]                in_d_valid,
    input  logic [NUM_BANK-1:0]                in_d_ready,
    output logic [NUM_BANK*OP_BITS-1:0]        in_d_opcode,
    output logic [NUM_BANK*SIZE_BITS-1:0]      in_d_size,
    output logic [NUM_BANK*SOURCE_BITS-1:0]    in_d_source,
    output logic [NUM_BANK*DATA_BITS-1:0]      in_d_data,
    output logic [NUM_BANK*3-1:0]              in_d_param,
    output logic                               mem_a_valid,
    input  logic                               mem_a_ready,
    output logic [OP_BITS-1:0]                 mem_a_opcode,
    output logic [SIZE_BITS-1:0]               mem_a_size,
    output logic [SOURCE_BITS+BANK_BITS-1:0]   mem_a_source,
    output logic [ADDRESS_BITS-1:0]            mem_a_address,
    output logic [MASK_BITS-1:0]               mem_a_mask,
    output logic [DATA_BITS-1:0]               mem_a_data,
    output logic [2:0]                         mem_a_param,
    input  logic                               mem_d_valid,
    output logic                               mem_d_ready,
    input  logic [OP_BITS-1:0]                 mem_d_opcode,
    input  logic [SIZE_BITS-1:0]               mem_d_size,
    input  logic [SOURCE_BITS+BANK_BITS-1:0]   mem_d_source,
    input  logic [DATA_BITS-1:0]               mem_d_data,
    input  logic [2:0]                         mem_d_param,
    output logic                               idle,
    output logic [1:0]                         err_sticky
);

    logic                    a_valid_q, a_valid_d;
    logic [BANK_BITS-1:0]    rr_q, rr_d, gnt_idx;
    logic [NUM_BANK-1:0]     elig, gnt;
    logic                    gnt_any, stage_free;
    logic [CNT_BITS-1:0]     cnt_q [NUM_BANK];
    logic [CNT_BITS-1:0]     cnt_d [NUM_BANK];
    logic [1:0]              err_q, err_d;
    logic                    idle_q, idle_d;
    logic [BANK_BITS-1:0]    d_bank;
    logic [NUM_BANK-1:0]     d_sel;
    logic                    d_in_range, d_fire;
    int                      idx;

    // Arbitration: first eligible bank starting at rr_q, only when the stage can accept.
    always_comb begin
        stage_free = !a_valid_q || mem_a_ready;
        gnt        = '0;
        gnt_idx    = '0;
        gnt_any    = 1'b0;
        idx        = 0;
        for (int i = 0; i < NUM_BANK; i++)
            elig[i] = in_a_valid[i] && (cnt_q[i] < CNT_BITS'(MAX_OUTSTANDING));
        for (int k = 0; k < NUM_BANK; k++) begin
            idx = (int'(rr_q) + k) % NUM_BANK;
            if (stage_free && !gnt_any && elig[idx]) begin
                gnt_any  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = BANK_BITS'(idx);
            end
        end
        rr_d      = gnt_any ? BANK_BITS'((int'(gnt_idx) + 1) % NUM_BANK) : rr_q;
        a_valid_d = gnt_any || (a_valid_q && !mem_a_ready);
    end

    assign in_a_ready = gnt;

    // D path is purely combinational; out-of-range tags are sunk so memory never stalls.
    assign d_bank = mem_d_source[SOURCE_BITS +: BANK_BITS];
    always_comb begin
        for (int i = 0; i < NUM_BANK; i++)
            d_sel[i] = (d_bank == BANK_BITS'(i));
        d_in_range  = |d_sel;
        in_d_valid  = d_sel & {NUM_BANK{mem_d_valid}};
        mem_d_ready = d_in_range ? |(d_sel & in_d_ready) : 1'b1;
        d_fire      = mem_d_valid && mem_d_ready && d_in_range;
    end

    assign in_d_opcode = {NUM_BANK{mem_d_opcode}};
    assign in_d_size   = {NUM_BANK{mem_d_size}};
    assign in_d_source = {NUM_BANK{mem_d_source[SOURCE_BITS-1:0]}};
    assign in_d_data   = {NUM_BANK{mem_d_data}};
    assign in_d_param  = {NUM_BANK{mem_d_param}};

    // A response for a bank with nothing in flight leaves the count at zero and flags an error.
    always_comb begin
        err_d  = err_q;
        idle_d = !a_valid_d;
        if (mem_d_valid && !d_in_range)
            err_d[0] = 1'b1;
        for (int i = 0; i < NUM_BANK; i++) begin
            if (d_fire && d_sel[i] && cnt_q[i] == '0) begin
                err_d[1] = 1'b1;
                cnt_d[i] = cnt_q[i] + CNT_BITS'(gnt[i]);
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_BITS'(gnt[i]) - CNT_BITS'(d_fire && d_sel[i]);
            end
            if (cnt_d[i] != '0)
                idle_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_valid_q     <= 1'b0;
            mem_a_opcode  <= '0;
            mem_a_size    <= '0;
            mem_a_source  <= '0;
            mem_a_address <= '0;
            mem_a_mask    <= '0;
            mem_a_data    <= '0;
            mem_a_param   <= '0;
            rr_q          <= '0;
            err_q         <= '0;
            idle_q        <= 1'b1;
            for (int i = 0; i < NUM_BANK; i++)
                cnt_q[i] <= '0;
        end else begin
            a_valid_q <= a_valid_d;
            rr_q      <= rr_d;
            err_q     <= err_d;
            idle_q    <= idle_d;
            for (int i = 0; i < NUM_BANK; i++)
                cnt_q[i] <= cnt_d[i];
            if (gnt_any) begin
                mem_a_opcode  <= in_a_opcode[int'(gnt_idx)*OP_BITS +: OP_BITS];
                mem_a_size    <= in_a_size[int'(gnt_idx)*SIZE_BITS +: SIZE_BITS];
                mem_a_source  <= {gnt_idx, in_a_source[int'(gnt_idx)*SOURCE_BITS +: SOURCE_BITS]};
                mem_a_address <= in_a_address[int'(gnt_idx)*ADDRESS_BITS +: ADDRESS_BITS];
                mem_a_mask    <= in_a_mask[int'(gnt_idx)*MASK_BITS +: MASK_BITS];
                mem_a_data    <= in_a_data[int'(gnt_idx)*DATA_BITS +: DATA_BITS];
                mem_a_param   <= in_a_param[int'(gnt_idx)*3 +: 3];
            end
        end
    end

    assign mem_a_valid = a_valid_q;
    assign idle        = idle_q;
    assign err_sticky  = err_q;

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Directed bench for l2_mem_arbiter: per-cycle comparison against a transaction-level model
// plus hand-computed expectations for each scenario.
module tb_l2_mem_arbiter;
    localparam int NB   = 2;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    logic [NB-1:0]     in_a_valid, in_a_ready, in_d_valid, in_d_ready;
    logic [NB*3-1:0]   in_a_opcode, in_a_size, in_a_param, in_d_opcode, in_d_size, in_d_param;
    logic [NB*8-1:0]   in_a_source, in_a_mask, in_d_source;
    logic [NB*32-1:0]  in_a_address;
    logic [NB*64-1:0]  in_a_data, in_d_data;
    logic              mem_a_valid, mem_a_ready, mem_d_valid, mem_d_ready, idle;
    logic [2:0]        mem_a_opcode, mem_a_size, mem_a_param, mem_d_opcode, mem_d_size, mem_d_param;
    logic [8:0]        mem_a_source, mem_d_source;
    logic [31:0]       mem_a_address;
    logic [7:0]        mem_a_mask;
    logic [63:0]       mem_a_data, mem_d_data;
    logic [1:0]        err_sticky;

    l2_mem_arbiter dut (
        .clk(clk), .rstn(rstn),
        .in_a_valid(in_a_valid), .in_a_ready(in_a_ready), .in_a_opcode(in_a_opcode),
        .in_a_size(in_a_size), .in_a_source(in_a_source), .in_a_address(in_a_address),
        .in_a_mask(in_a_mask), .in_a_data(in_a_data), .in_a_param(in_a_param),
        .in_d_valid(in_d_valid), .in_d_ready(in_d_ready), .in_d_opcode(in_d_opcode),
        .in_d_size(in_d_size), .in_d_source(in_d_source), .in_d_data(in_d_data),
        .in_d_param(in_d_param),
        .mem_a_valid(mem_a_valid), .mem_a_ready(mem_a_ready), .mem_a_opcode(mem_a_opcode),
        .mem_a_size(mem_a_size), .mem_a_source(mem_a_source), .mem_a_address(mem_a_address),
        .mem_a_mask(mem_a_mask), .mem_a_data(mem_a_data), .mem_a_param(mem_a_param),
        .mem_d_valid(mem_d_valid), .mem_d_ready(mem_d_ready), .mem_d_opcode(mem_d_opcode),
        .mem_d_size(mem_d_size), .mem_d_source(mem_d_source), .mem_d_data(mem_d_data),
        .mem_d_param(mem_d_param),
        .idle(idle), .err_sticky(err_sticky)
    );

    int tests = 0;
    int fails = 0;

    // Model state: what the memory port holds, per-bank in-flight counts, rotation start.
    int          m_cnt [NB];
    bit          m_v;
    logic [8:0]  m_src;
    logic [31:0] m_addr;
    logic [2:0]  m_op;
    int          m_rr;
    logic [1:0]  m_err;
    bit          m_idle;
    logic [NB-1:0] last_rdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int m_grant();
        if (m_v && !mem_a_ready) return -1;
        for (int k = 0; k < NB; k++) begin
            int i;
            i = (m_rr + k) % NB;
            if (in_a_valid[i] && m_cnt[i] < MAXO) return i;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        int g, b;
        logic [NB-1:0] er, edv;
        logic [7:0] s;
        g   = m_grant();
        b   = int'(mem_d_source[8]);
        er  = '0;
        edv = '0;
        s   = mem_d_source[7:0];
        if (g >= 0) er[g] = 1'b1;
        if (mem_d_valid) edv[b] = 1'b1;
        chk("in_a_ready", in_a_ready, er);
        chk("mem_a_valid", mem_a_valid, m_v);
        if (m_v) begin
            chk("mem_a_source", mem_a_source, m_src);
            chk("mem_a_address", mem_a_address, m_addr);
            chk("mem_a_opcode", mem_a_opcode, m_op);
        end
        chk("idle", idle, m_idle);
        chk("err_sticky", err_sticky, m_err);
        chk("in_d_valid", in_d_valid, edv);
        chk("mem_d_ready", mem_d_ready, in_d_ready[b]);
        chk("in_d_source", in_d_source, {s, s});
        last_rdy = in_a_ready;
    endtask

    task automatic model_update();
        int g, b;
        bit df;
        g  = m_grant();
        b  = int'(mem_d_source[8]);
        df = mem_d_valid && in_d_ready[b];
        if (g >= 0) begin
            m_v    = 1'b1;
            m_src  = {g[0], in_a_source[g*8 +: 8]};
            m_addr = in_a_address[g*32 +: 32];
            m_op   = in_a_opcode[g*3 +: 3];
            m_rr   = (g + 1) % NB;
        end else if (mem_a_ready) begin
            m_v = 1'b0;
        end
        if (df) begin
            if (m_cnt[b] == 0) m_err[1] = 1'b1;
            else m_cnt[b]--;
        end
        if (g >= 0) m_cnt[g]++;
        m_idle = !m_v;
        for (int i = 0; i < NB; i++)
            if (m_cnt[i] != 0) m_idle = 1'b0;
    endtask

    task automatic cyc();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        in_a_valid = '0; in_a_opcode = '0; in_a_size = '0; in_a_param = '0;
        in_a_source = '0; in_a_mask = '0; in_a_address = '0; in_a_data = '0;
        in_d_ready = '0; mem_a_ready = 1'b1; mem_d_valid = 1'b0;
        mem_d_opcode = '0; mem_d_size = '0; mem_d_param = '0;
        mem_d_source = '0; mem_d_data = '0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        chk("rst_mem_a_valid", mem_a_valid, 1'b0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_err", err_sticky, 2'b00);
        chk("rst_addr", mem_a_address, 32'h0);
        m_v = 1'b0; m_src = '0; m_addr = '0; m_op = '0;
        m_rr = 0; m_err = '0; m_idle = 1'b1;
        for (int i = 0; i < NB; i++) m_cnt[i] = 0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic set_bank(input int i, input logic [2:0] op, input logic [7:0] src,
                            input logic [31:0] addr);
        in_a_opcode[i*3 +: 3]    = op;
        in_a_source[i*8 +: 8]    = src;
        in_a_address[i*32 +: 32] = addr;
        in_a_data[i*64 +: 64]    = {32'hDA7A0000, addr};
        in_a_mask[i*8 +: 8]      = 8'hFF;
    endtask

    initial begin
        int n;
        clear_inputs();
        #1;
        do_reset();

        // Single Get from bank 0 and its response.
        set_bank(0, 3'd4, 8'h05, 32'h9000_0000);
        in_a_valid = 2'b01;
        cyc();
        chk("t1_valid", mem_a_valid, 1'b1);
        chk("t1_source", mem_a_source, 9'h005);
        chk("t1_idle_low", idle, 1'b0);
        in_a_valid = '0;
        cyc();
        mem_d_valid = 1'b1; mem_d_source = 9'h005; in_d_ready = 2'b01;
        mem_d_data = 64'h1234_5678_9ABC_DEF0; mem_d_opcode = 3'd1;
        #1;
        chk("t1_d_valid", in_d_valid, 2'b01);
        chk("t1_d_source", in_d_source[7:0], 8'h05);
        chk("t1_d_ready", mem_d_ready, 1'b1);
        cyc();
        mem_d_valid = 1'b0;
        chk("t1_idle_back", idle, 1'b1);

        // Two banks contending: strict alternation starting at bank 0.
        clear_inputs();
        do_reset();
        set_bank(0, 3'd4, 8'h11, 32'h0000_1000);
        set_bank(1, 3'd4, 8'h22, 32'h0000_2000);
        in_a_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("t2_alternate", last_rdy, (k % 2 == 1) ? 2'b10 : 2'b01);
        end

        // Backpressure: stage contents frozen and no grants.
        mem_a_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t3_stall_rdy", last_rdy, 2'b00);
            chk("t3_stall_src", mem_a_source, 9'h122);
            chk("t3_stall_addr", mem_a_address, 32'h0000_2000);
        end
        mem_a_ready = 1'b1;
        #1;
        chk("t3_resume_rdy", in_a_ready, 2'b01);
        cyc();

        // Bank 1 saturates at MAX_OUTSTANDING; bank 0 keeps flowing.
        clear_inputs();
        do_reset();
        set_bank(0, 3'd4, 8'h11, 32'h0000_1000);
        set_bank(1, 3'd0, 8'h22, 32'h0000_2000);
        in_a_valid = 2'b10;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t4_fill", last_rdy, 2'b10);
        end
        in_a_valid = 2'b11;
        cyc();
        chk("t4_held_a", last_rdy, 2'b01);
        cyc();
        chk("t4_held_b", last_rdy, 2'b01);
        mem_d_valid = 1'b1; mem_d_source = 9'h122; in_d_ready = 2'b11;
        cyc();
        chk("t4_d_cycle", last_rdy, 2'b01);
        mem_d_valid = 1'b0;
        cyc();
        chk("t4_unblocked", last_rdy, 2'b10);

        // Grant and response for the same bank in one cycle leave the count unchanged.
        clear_inputs();
        do_reset();
        set_bank(0, 3'd4, 8'h11, 32'h0000_1000);
        in_a_valid = 2'b01;
        cyc();
        cyc();
        mem_d_valid = 1'b1; mem_d_source = 9'h011; in_d_ready = 2'b01;
        cyc();
        chk("t5_both", last_rdy, 2'b01);
        mem_d_valid = 1'b0;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (last_rdy[0]) n++;
        end
        chk("t5_room_left", n, 2);

        // Response to a bank with nothing outstanding, then reset mid-flight.
        clear_inputs();
        do_reset();
        mem_d_valid = 1'b1; mem_d_source = 9'h100; in_d_ready = 2'b10;
        cyc();
        mem_d_valid = 1'b0;
        chk("t6_err", err_sticky, 2'b10);
        set_bank(0, 3'd4, 8'h33, 32'h0000_3000);
        in_a_valid = 2'b01;
        cyc();
        chk("t6_loaded", mem_a_valid, 1'b1);
        do_reset();
        clear_inputs();
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
